mult_seq_ctrl: RTL

Multi-cycle sequencer for the MIPS32 MULT/MULTU instructions, producing a 64-bit HI/LO product by shift-and-add. It time-multiplexes one 32-bit mixed adder (`bit_32_mixed_adder_8`) over 32 iterations, plus optional sign-fix passes. It sits beside the ALU in EX and stalls the pipeline via `ready_out` until `done_out`.

---
 rtl/mult_seq_pkg.sv | 24 ++
 rtl/bit_32_mixed_adder_8.sv | 27 ++
 rtl/mult_seq_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the MULT/MULTU shift-and-add sequencer.
// Optional feature macro used by the sequencer: MULT_SEQ_SIGNED_EN.
package mult_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NEGA = 3'd1,
    ST_NEGB = 3'd2,
    ST_MUL  = 3'd3,
    ST_NEGL = 3'd4,
    ST_NEGH = 3'd5,
    ST_DONE = 3'd6
  } mult_state_e;

  localparam int MULT_ITERS   = 32;
  localparam int LAT_SIGNED   = 36;
  localparam int LAT_UNSIGNED = 33;

  // Partial-product select: the multiplicand when the current multiplier bit is set.
  function automatic logic [31:0] pp_sel(input logic sel, input logic [31:0] v);
    return sel ? v : 32'h0000_0000;
  endfunction

endpackage

// File: rtl/bit_32_mixed_adder_8.sv
// 32-bit adder built from four 8-bit carry-chained slices, with bitwise side outputs.
module bit_32_mixed_adder_8 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] s_o,
  output logic        c_o,
  output logic [31:0] and_o,
  output logic [31:0] or_o,
  output logic [31:0] xor_o
);

  logic [4:0] cy;

  assign cy[0] = c_i;

  for (genvar g = 0; g < 4; g++) begin : g_slice
    assign {cy[g+1], s_o[8*g +: 8]} = {1'b0, a_i[8*g +: 8]} + {1'b0, b_i[8*g +: 8]}
                                      + {8'h00, cy[g]};
  end

  assign c_o   = cy[4];
  assign and_o = a_i & b_i;
  assign or_o  = a_i | b_i;
  assign xor_o = a_i ^ b_i;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle MULT/MULTU sequencer: one shared 32-bit adder, shift-and-add over
// ITERS cycles, with magnitude/negate passes for signed operands.
// Optional feature macro: MULT_SEQ_SIGNED_EN (signed MULT support; undefined = MULTU only).
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int ITERS = MULT_ITERS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        signed_in,
  input  logic [31:0] rs_in,
  input  logic [31:0] rt_in,
  output logic        ready_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CNT_W = $clog2(ITERS + 1);

`ifdef MULT_SEQ_SIGNED_EN
  localparam bit PRIME = 1'b0;
`else
  // Without the sign passes the first MUL cycle is an idle settle cycle, so the
  // unsigned path keeps its LAT_UNSIGNED stall length.
  localparam bit PRIME = 1'b1;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1 + int'(PRIME));

  mult_state_e      state_q, state_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      mq_q, mq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             iter_en;

  logic [31:0]      add_a, add_b, add_s;
  logic             add_c, add_co;
  logic [31:0]      unused_and_w, unused_or_w, unused_xor_w;

`ifdef MULT_SEQ_SIGNED_EN
  logic             sgn_q, sgn_d;
  logic             neg_q, neg_d;
  logic             cy_q, cy_d;
`else
  logic             unused_signed_w;
  assign unused_signed_w = signed_in;
`endif

  bit_32_mixed_adder_8 u_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .c_i   (add_c),
    .s_o   (add_s),
    .c_o   (add_co),
    .and_o (unused_and_w),
    .or_o  (unused_or_w),
    .xor_o (unused_xor_w)
  );

  assign iter_en = !(PRIME && (cnt_q == '0));

  // Adder operand mux: multiply step by default, two's-complement passes otherwise.
  always_comb begin
    add_a = acc_q;
    add_b = pp_sel(mq_q[0], mcand_q);
    add_c = 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
    case (state_q)
      ST_NEGA: begin
        add_a = ~mcand_q;
        add_b = '0;
        add_c = 1'b1;
      end
      ST_NEGB, ST_NEGL: begin
        add_a = ~mq_q;
        add_b = '0;
        add_c = 1'b1;
      end
      ST_NEGH: begin
        add_a = ~acc_q;
        add_b = '0;
        add_c = cy_q;
      end
      default: ;
    endcase
`endif
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
`ifdef MULT_SEQ_SIGNED_EN
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    cy_d    = cy_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          mcand_d = rs_in;
          mq_d    = rt_in;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef MULT_SEQ_SIGNED_EN
          sgn_d   = signed_in;
          neg_d   = signed_in & (rs_in[31] ^ rt_in[31]);
          state_d = ST_NEGA;
`else
          state_d = ST_MUL;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef MULT_SEQ_SIGNED_EN
      ST_NEGA: begin
        if (sgn_q && mcand_q[31]) mcand_d = add_s;
        state_d = ST_NEGB;
      end
      ST_NEGB: begin
        if (sgn_q && mq_q[31]) mq_d = add_s;
        state_d = ST_MUL;
      end
`endif
      ST_MUL: begin
        if (iter_en) begin
          acc_d = {add_co, add_s[31:1]};
          mq_d  = {add_s[0], mq_q[31:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
`ifdef MULT_SEQ_SIGNED_EN
          state_d = ST_NEGL;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef MULT_SEQ_SIGNED_EN
      ST_NEGL: begin
        if (neg_q) begin
          mq_d = add_s;
          cy_d = add_co;
        end
        state_d = ST_NEGH;
      end
      ST_NEGH: begin
        if (neg_q) acc_d = add_s;
        state_d = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand, accumulator and counter registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      cy_q    <= 1'b0;
`endif
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
`ifdef MULT_SEQ_SIGNED_EN
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      cy_q    <= cy_d;
`endif
    end
  end

  assign ready_out = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy_out  = !ready_out;
  assign done_out  = (state_q == ST_DONE);
  assign hi_out    = acc_q;
  assign lo_out    = mq_q;

endmodule
